// File: rtl/greater_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined magnitude comparator.
// Sizes every level of the group-and-merge tree from the operand width.
package greater_pipe_pkg;

    localparam int GROUP_W = 3;

    typedef struct packed {
        logic gt;
        logic eq;
    } cmp_t;

    // Stands in for a group that does not exist at the top of a level.
    localparam cmp_t CMP_PAD = '{gt: 1'b0, eq: 1'b1};

    function automatic int ngroups(input int width);
        return (width + GROUP_W - 1) / GROUP_W;
    endfunction

    function automatic int clog4(input int n);
        int m;
        int r;
        m = n;
        r = 0;
        while (m > 1) begin
            m = (m + 3) / 4;
            r++;
        end
        return r;
    endfunction

    function automatic int lat(input int width);
        return 1 + clog4(ngroups(width));
    endfunction

    function automatic int lvl_n(input int n0, input int l);
        int m;
        m = n0;
        for (int i = 0; i < l; i++) m = (m + 3) / 4;
        return m;
    endfunction

    // Position of level l inside the flattened node vector.
    function automatic int lvl_off(input int n0, input int l);
        int s;
        s = 0;
        for (int i = 0; i < l; i++) s += lvl_n(n0, i);
        return s;
    endfunction

endpackage

// File: rtl/greater_merge4.sv
// Combinational 4:1 merge of compare results, element 3 most significant.
// The highest unequal group decides gt.
module greater_merge4
    import greater_pipe_pkg::*;
(
    input  cmp_t [3:0] grp,
    output cmp_t       res
);

    always_comb begin
        res.eq = grp[0].eq & grp[1].eq & grp[2].eq & grp[3].eq;
        res.gt = grp[3].eq
               ? (grp[2].eq ? (grp[1].eq ? grp[0].gt : grp[1].gt) : grp[2].gt)
               : grp[3].gt;
    end

endmodule

// File: rtl/greater_pipe.sv
// Pipelined, flow-controlled unsigned a>b / a==b comparator with a tag,
// one register stage per tree level and a single global stall enable.
module greater_pipe
    import greater_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N0    = ngroups(WIDTH);
    localparam int NLV   = clog4(N0);
    localparam int LAT   = NLV + 1;
    localparam int TOTAL = lvl_off(N0, NLV + 1);
    localparam int PW    = N0 * GROUP_W;

    logic                en;
    logic [PW-1:0]       ap;
    logic [PW-1:0]       bp;
    cmp_t [TOTAL-1:0]    node_d;
    cmp_t [TOTAL-1:0]    node_q;
    logic [LAT-1:0]      vld_q;
    logic [TAG_W-1:0]    tag_q [LAT];

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    assign ap = PW'(a);
    assign bp = PW'(b);

    for (genvar j = 0; j < N0; j++) begin : g_leaf
        assign node_d[j].gt = ap[j*GROUP_W +: GROUP_W] > bp[j*GROUP_W +: GROUP_W];
        assign node_d[j].eq = ap[j*GROUP_W +: GROUP_W] == bp[j*GROUP_W +: GROUP_W];
    end

    for (genvar l = 1; l <= NLV; l++) begin : g_lvl
        localparam int NP = lvl_n(N0, l - 1);
        localparam int NC = lvl_n(N0, l);
        localparam int OP = lvl_off(N0, l - 1);
        localparam int OC = lvl_off(N0, l);
        for (genvar j = 0; j < NC; j++) begin : g_node
            cmp_t [3:0] grp;
            for (genvar i = 0; i < 4; i++) begin : g_in
                if (4 * j + i < NP) begin : g_real
                    assign grp[i] = node_q[OP + 4*j + i];
                end else begin : g_pad
                    assign grp[i] = CMP_PAD;
                end
            end
            greater_merge4 u_merge (
                .grp (grp),
                .res (node_d[OC + j])
            );
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            node_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (en) begin
            node_q   <= node_d;
            vld_q[0] <= in_valid & en;
            tag_q[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign gt        = node_q[TOTAL-1].gt;
    assign eq        = node_q[TOTAL-1].eq;

endmodule

// File: tb/tb_greater_pipe.sv
// Directed bench for greater_pipe: a 32-bit instance (LAT=3) and a
// 2-bit instance (LAT=1) sharing clock and reset.
module tb_greater_pipe;

    logic        clk = 1'b0;
    logic        arst;

    logic        in_valid, in_ready, out_valid, out_ready, gt, eq;
    logic [31:0] a, b;
    logic [3:0]  in_tag, out_tag;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, gt2, eq2;
    logic [1:0]  a2, b2;
    logic [0:0]  in_tag2, out_tag2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    greater_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .arst(arst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .eq(eq), .out_tag(out_tag)
    );

    greater_pipe #(.WIDTH(2), .TAG_W(1)) dut2 (
        .clk(clk), .arst(arst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .gt(gt2), .eq(eq2), .out_tag(out_tag2)
    );

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated pair through the 32-bit instance, checking exact latency.
    task automatic run1(input string tg, input logic [31:0] va, input logic [31:0] vb,
                        input logic [3:0] t, input logic egt, input logic eeq);
        in_valid = 1'b1;
        a = va;
        b = vb;
        in_tag = t;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tg, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tg, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tg, "_gt"}, {31'd0, gt}, {31'd0, egt});
        chk({tg, "_eq"}, {31'd0, eq}, {31'd0, eeq});
        chk({tg, "_tag"}, {28'd0, out_tag}, {28'd0, t});
        tick();
    endtask

    logic [1:0] bp_exp [8];
    int         sent, rcv;
    logic       held;
    logic       h_gt, h_eq;
    logic [3:0] h_tag;
    logic       acc;

    initial begin
        arst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; in_tag2 = '0; out_ready2 = 1'b1;
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_gt", {31'd0, gt}, 32'd0);
        chk("rst_eq", {31'd0, eq}, 32'd0);
        chk("rst_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        arst = 1'b0;
        tick();

        run1("t1", 32'd5, 32'd3, 4'd1, 1'b1, 1'b0);
        run1("t2_eq", 32'hDEADBEEF, 32'hDEADBEEF, 4'd2, 1'b0, 1'b1);
        run1("t2_lt", 32'hDEADBEEE, 32'hDEADBEEF, 4'd3, 1'b0, 1'b0);
        run1("t3_msb", 32'h8000_0000, 32'h7FFF_FFFF, 4'd4, 1'b1, 1'b0);
        run1("t3_lsb", 32'h1, 32'h0, 4'd5, 1'b1, 1'b0);
        run1("t3_mid", 32'h4000_0000, 32'h4000_0001, 4'd6, 1'b0, 1'b0);

        // a = 3*tag, b = 6 ; entries are {gt, eq}
        bp_exp = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        sent = 0;
        rcv  = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 8);
            a         = 32'(sent * 3);
            b         = 32'd6;
            in_tag    = 4'(sent);
            #1;
            if (out_valid) begin
                chk("bp_ready", {31'd0, in_ready}, {31'd0, out_ready});
                if (held) begin
                    chk("bp_hold_gt", {31'd0, gt}, {31'd0, h_gt});
                    chk("bp_hold_eq", {31'd0, eq}, {31'd0, h_eq});
                    chk("bp_hold_tag", {28'd0, out_tag}, {28'd0, h_tag});
                end
                if (out_ready) begin
                    chk("bp_tag", {28'd0, out_tag}, 32'(rcv));
                    chk("bp_gt", {31'd0, gt}, {31'd0, bp_exp[rcv][1]});
                    chk("bp_eq", {31'd0, eq}, {31'd0, bp_exp[rcv][0]});
                    rcv++;
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    h_gt  = gt;
                    h_eq  = eq;
                    h_tag = out_tag;
                end
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) sent++;
        end
        chk("bp_count", 32'(rcv), 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_nodup", {31'd0, out_valid}, 32'd0);
            tick();
        end

        in_valid = 1'b1;
        a = 32'd7; b = 32'd1; in_tag = 4'd10;
        tick();
        in_tag = 4'd11;
        tick();
        in_valid = 1'b0;
        arst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        tick();
        arst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
            tick();
        end
        run1("t5_new", 32'd2, 32'd9, 4'd9, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            in_valid2 = 1'b1;
            a2 = 2'(i >> 2);
            b2 = 2'(i);
            in_tag2 = 1'(i);
            #1;
            chk("w2_ready", {31'd0, in_ready2}, 32'd1);
            tick();
            chk("w2_valid", {31'd0, out_valid2}, 32'd1);
            chk("w2_gt", {31'd0, gt2}, {31'd0, ((i >> 2) > (i & 3))});
            chk("w2_eq", {31'd0, eq2}, {31'd0, ((i >> 2) == (i & 3))});
            chk("w2_tag", {31'd0, out_tag2}, 32'(i & 1));
        end
        in_valid2 = 1'b0;
        tick();
        chk("w2_drain", {31'd0, out_valid2}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
